// File: rtl/register_file_mp.sv
`default_nettype none
// ============================================================================
// Module   : register_file_mp
// Purpose  : Multi-ported register file with selectable read timing
//            (async / write-first registered / read-first registered),
//            optional hard-wired zero register and a per-register busy
//            scoreboard reported through each read port.
// Revision : 1.0 - initial release
// ============================================================================
module register_file_mp #(
    parameter int AWL      = 5,
    parameter int DWL      = 32,
    parameter int NRP      = 2,
    parameter int NWP      = 2,
    parameter int MODE     = 0,
    parameter int ZERO_REG = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NWP-1:0]       wen,
    input  logic [NWP*AWL-1:0]   WA,
    input  logic [NWP*DWL-1:0]   WD,
    input  logic [NRP*AWL-1:0]   RA,
    output logic [NRP*DWL-1:0]   RD,
    input  logic                 sb_set,
    input  logic [AWL-1:0]       sb_set_addr,
    input  logic                 sb_clr,
    input  logic [AWL-1:0]       sb_clr_addr,
    output logic [NRP-1:0]       busy
);

    localparam int DEPTH     = 1 << AWL;
    localparam bit c_ZERO_EN = (ZERO_REG != 0);

    logic [DWL-1:0]   r_mem [DEPTH];
    logic [DEPTH-1:0] r_busy;
    logic [DEPTH-1:0] w_busy_nxt;

    // Next scoreboard state: clear first so a same-address set overrides it
    always_comb begin
        w_busy_nxt = r_busy;
        if (sb_clr) begin
            w_busy_nxt[sb_clr_addr] = 1'b0;
        end
        if (sb_set && !(c_ZERO_EN && (sb_set_addr == '0))) begin
            w_busy_nxt[sb_set_addr] = 1'b1;
        end
    end

    // Array and scoreboard update; ascending port order lets the highest
    // enabled port win a write-write collision
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_mem[k] <= '0;
            end
            r_busy <= '0;
        end else begin
            for (int j = 0; j < NWP; j++) begin
                if (wen[j] && !(c_ZERO_EN && (WA[j*AWL +: AWL] == '0))) begin
                    r_mem[WA[j*AWL +: AWL]] <= WD[j*DWL +: DWL];
                end
            end
            r_busy <= w_busy_nxt;
        end
    end

    generate
        for (genvar i = 0; i < NRP; i++) begin : g_rd
            logic [AWL-1:0] w_ra;
            logic           w_ra_zero;
            logic [DWL-1:0] w_stored;

            assign w_ra      = RA[i*AWL +: AWL];
            assign w_ra_zero = c_ZERO_EN && (w_ra == '0);
            assign w_stored  = w_ra_zero ? '0 : r_mem[w_ra];

            if (MODE == 0) begin : g_mode0
                assign RD[i*DWL +: DWL] = w_stored;
                assign busy[i]          = r_busy[w_ra];
            end else if (MODE == 1) begin : g_mode1
                logic           w_byp_hit;
                logic [DWL-1:0] w_byp_data;
                logic [DWL-1:0] r_rd;
                logic           r_bsy;

                // Same-edge write to this read address; highest port wins
                always_comb begin
                    w_byp_hit  = 1'b0;
                    w_byp_data = '0;
                    for (int j = 0; j < NWP; j++) begin
                        if (wen[j] && (WA[j*AWL +: AWL] == w_ra)) begin
                            w_byp_hit  = 1'b1;
                            w_byp_data = WD[j*DWL +: DWL];
                        end
                    end
                end

                // Write-first registered read of data and busy
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        r_rd  <= '0;
                        r_bsy <= 1'b0;
                    end else begin
                        if (w_ra_zero) begin
                            r_rd <= '0;
                        end else if (w_byp_hit) begin
                            r_rd <= w_byp_data;
                        end else begin
                            r_rd <= w_stored;
                        end
                        r_bsy <= w_busy_nxt[w_ra];
                    end
                end

                assign RD[i*DWL +: DWL] = r_rd;
                assign busy[i]          = r_bsy;
            end else begin : g_mode2
                logic [DWL-1:0] r_rd;
                logic           r_bsy;

                // Read-first registered read: capture pre-edge contents
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        r_rd  <= '0;
                        r_bsy <= 1'b0;
                    end else begin
                        r_rd  <= w_stored;
                        r_bsy <= r_busy[w_ra];
                    end
                end

                assign RD[i*DWL +: DWL] = r_rd;
                assign busy[i]          = r_bsy;
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: doc/register_file_mp.md
Name: register_file_mp

Overview:
- Multi-ported, parametrised register file for the processor datapath.
- Configurable numbers of read and write ports, and three read modes: asynchronous, write-first registered, read-first registered.
- Optional hard-wired zero register and asynchronous clear of the whole array.
- Per-register busy scoreboard so issue logic can detect pending writes, with busy reported per read port.

Parameters:
- AWL, 5, address word length; depth = 2**AWL.
- DWL, 32, data word length.
- NRP, 2, number of read ports (>=1).
- NWP, 2, number of write ports (>=1).
- MODE, 0, read mode: 0 asynchronous read, 1 write-first registered read, 2 read-first registered read.
- ZERO_REG, 1, 1: register 0 reads 0, ignores writes and is never busy; 0: register 0 is ordinary.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- wen  in  NWP  per-write-port enable.
- WA  in  NWP*AWL  write addresses; port j occupies [j*AWL +: AWL].
- WD  in  NWP*DWL  write data; port j occupies [j*DWL +: DWL].
- RA  in  NRP*AWL  read addresses; port i occupies [i*AWL +: AWL].
- RD  out  NRP*DWL  read data per port.
- sb_set  in  1  mark register sb_set_addr busy.
- sb_set_addr  in  AWL  register to mark busy.
- sb_clr  in  1  mark register sb_clr_addr not busy.
- sb_clr_addr  in  AWL  register to clear.
- busy  out  NRP  busy flag of the register addressed by each read port.

Behaviour:
- Reset (rst_n low, asynchronous): all 2**AWL registers = 0, all busy bits = 0. In MODE 1/2, RD = 0 and busy = 0 immediately. In MODE 0, outputs follow the cleared array (0). Reset has priority over every other input. Deassertion takes effect at the next rising edge.
- Write, at posedge:
  - For each j with wen[j]=1, reg[WA_j] <= WD_j.
  - With ZERO_REG=1, writes to address 0 are dropped.
  - Write-write collision (same address, multiple enabled ports): highest-index port wins. Other ports' data is discarded, with no error.
- Read, MODE 0:
  - RD_i = reg[RA_i] combinationally; 0 latency.
  - A write in the current cycle is visible only after the edge (no bypass).
- Read, MODE 1 (write-first):
  - RD_i registered; 1-cycle latency.
  - If an enabled write targets RA_i on the same edge, RD_i takes the winning WD (highest index), not the stored value.
- Read, MODE 2 (read-first):
  - RD_i registered; 1-cycle latency.
  - RD_i takes the value stored before the edge, even if written on that edge.
- Zero register: with ZERO_REG=1, reads of address 0 return 0 in all modes, including the bypass path.
- Scoreboard, at posedge:
  - sb_set sets busy[sb_set_addr]; sb_clr clears busy[sb_clr_addr].
  - Same address with both set and clr: set wins (new producer issued).
  - Different addresses: both take effect.
  - With ZERO_REG=1, sb_set to address 0 is ignored.
  - Writes via wen do not change busy bits; the scoreboard is software-controlled.
- busy output timing follows MODE:
  - MODE 0: combinational from current bits.
  - MODE 1: registered; reflects same-edge set/clr to RA_i (set priority).
  - MODE 2: registered; pre-edge value.
- Address widths are exact, so no out-of-range addresses are possible. All ports are independent; any read port may alias any other read or write port.

Test Plan:
- Reset then read: rst_n=0, release, read every address on both ports -> RD=0 and busy=0 for all 32 registers in all three MODE builds.
- Zero register: MODE 0, ZERO_REG=1, write WA0=0 WD0=32'hDEAD_BEEF, then read RA0=0 -> RD0=0. Repeat with ZERO_REG=0 -> RD0=32'hDEAD_BEEF.
- Write collision: both ports wen=1, WA=3, WD0=32'h1111, WD1=32'h2222 -> reg3 reads 32'h2222.
- Read-during-write, reg5 preloaded with 32'hAAAA, same edge write 32'h5555 to reg5 with RA0=5. Next cycle RD0:
  - MODE 1 -> 32'h5555.
  - MODE 2 -> 32'hAAAA.
  - MODE 0 before the edge -> 32'hAAAA, after the edge -> 32'h5555.
- Scoreboard: sb_set addr 7, next edge sb_set and sb_clr both addr 7 -> busy stays 1. Then sb_clr addr 7 alone -> busy=0. In MODE 2, a busy read aliasing the set edge shows the old value for one cycle.
- Mid-operation reset: after loading regs 1..4 and setting busy on 2, pull rst_n low asynchronously between edges:
  - RD and busy go to 0 without waiting for a clock (MODE 1/2).
  - After release, all reads return 0.
